router_port_ctrl: RTL and testbench

//   Per-packet output-port controller for the 1x3 router.
//   - Latches the destination address of each packet and steers the write-side FSM's write strobe to one of the three output FIFOs.
//   - Reflects the selected FIFO's full flag back to the FSM and presents valid_out to each downstream reader.
//   - Runs a per-port stall timer that issues a one-cycle soft reset when a reader abandons its FIFO.
//   - Sits between the write-side FSM/register block and the three output FIFOs.

---
 rtl/router_port_ctrl.sv | 129 ++++++++++++
 tb/tb_router_port_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_ctrl.sv
// Output-port controller for the 1x3 router: address latch, write steering, stall timers.
// Define ROUTER_DROP_CNT_EN to add the per-port saturating timeout counters drop_cnt_0..2.
module router_port_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       detect_add,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic       soft_rst_0,
  output logic       soft_rst_1,
  output logic       soft_rst_2,
`ifdef ROUTER_DROP_CNT_EN
  output logic [7:0] drop_cnt_0,
  output logic [7:0] drop_cnt_1,
  output logic [7:0] drop_cnt_2,
`endif
  output logic       addr_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       addr_q;
  logic [2:0]       empty;
  logic [2:0]       rd;
  logic [2:0]       full;
  logic [2:0]       srst;
  logic [CNT_W-1:0] cnt [3];

  assign empty = {empty_2, empty_1, empty_0};
  assign rd    = {read_enb_2, read_enb_1, read_enb_0};
  assign full  = {full_2, full_1, full_0};

  assign valid_out_0 = ~empty_0;
  assign valid_out_1 = ~empty_1;
  assign valid_out_2 = ~empty_2;

  assign soft_rst_0 = srst[0];
  assign soft_rst_1 = srst[1];
  assign soft_rst_2 = srst[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= 2'b00;
      addr_err <= 1'b0;
    end else if (detect_add && pkt_valid) begin
      addr_q   <= data_in;
      addr_err <= (data_in == 2'b11);
    end
  end

  // Address 3 has no port: the byte is dropped and never stalls the FSM.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    unique case (addr_q)
      2'd0: begin
        write_enb[0] = write_enb_reg;
        fifo_full    = full[0];
      end
      2'd1: begin
        write_enb[1] = write_enb_reg;
        fifo_full    = full[1];
      end
      2'd2: begin
        write_enb[2] = write_enb_reg;
        fifo_full    = full[2];
      end
      default: ;
    endcase
    if (reset) write_enb = 3'b000;
  end

  // A read or an empty FIFO clears the count, even on a would-be timeout edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      srst <= 3'b000;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        srst[i] <= 1'b0;
        if (empty[i] || rd[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i]  <= '0;
          srst[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef ROUTER_DROP_CNT_EN
  logic [7:0] drop [3];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) drop[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 3; i++)
        if (srst[i] && drop[i] != 8'hFF)
          drop[i] <= drop[i] + 8'h01;
    end
  end

  assign drop_cnt_0 = drop[0];
  assign drop_cnt_1 = drop[1];
  assign drop_cnt_2 = drop[2];
`endif

endmodule

// File: tb/tb_router_port_ctrl.sv
// Scoreboard bench for router_port_ctrl: directed scenarios plus randomized traffic.
// Define ROUTER_DROP_CNT_EN to also exercise drop_cnt saturation.
module tb_router_port_ctrl;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       detect_add;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       addr_err;
`ifdef ROUTER_DROP_CNT_EN
  logic [7:0] drop_cnt_0, drop_cnt_1, drop_cnt_2;
`endif

  always #5 clk = ~clk;

  router_port_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .detect_add(detect_add), .pkt_valid(pkt_valid),
    .data_in(data_in), .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1),
    .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
    .valid_out_2(valid_out_2),
    .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1),
    .soft_rst_2(soft_rst_2),
`ifdef ROUTER_DROP_CNT_EN
    .drop_cnt_0(drop_cnt_0), .drop_cnt_1(drop_cnt_1),
    .drop_cnt_2(drop_cnt_2),
`endif
    .addr_err(addr_err)
  );

  typedef struct packed {
    logic [2:0]  we;
    logic        ff;
    logic [2:0]  vo;
    logic [2:0]  sr;
    logic        ae;
    logic [23:0] dc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: latched port, stall run lengths, pending pulses.
  int m_addr = 0;
  bit m_aerr = 0;
  int m_run[3];
  bit m_sr[3];
  int m_drop[3];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_aerr = 0;
    for (int i = 0; i < 3; i++) begin
      m_run[i]  = 0;
      m_sr[i]   = 0;
      m_drop[i] = 0;
    end
  endtask

  task automatic apply(input bit rst, input bit da, input bit pv,
                       input logic [1:0] din, input bit wer,
                       input logic [2:0] rd, input logic [2:0] em,
                       input logic [2:0] fu);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; detect_add = da; pkt_valid = pv;
    data_in = din; write_enb_reg = wer;
    {read_enb_2, read_enb_1, read_enb_0} = rd;
    {empty_2, empty_1, empty_0} = em;
    {full_2, full_1, full_0} = fu;
    e.we = (rst || m_addr == 3 || !wer) ? 3'b000 : 3'(1 << m_addr);
    e.ff = (m_addr == 3) ? 1'b0 : fu[m_addr];
    e.vo = ~em;
    e.sr = {m_sr[2], m_sr[1], m_sr[0]};
    e.ae = m_aerr;
    e.dc = {m_drop[2][7:0], m_drop[1][7:0], m_drop[0][7:0]};
    q.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      if (da && pv) begin
        m_addr = int'(din);
        m_aerr = (din == 2'b11);
      end
      for (int i = 0; i < 3; i++) begin
        if (m_sr[i] && m_drop[i] < 255) m_drop[i]++;
        m_sr[i] = 0;
        if (!em[i] && !rd[i]) begin
          m_run[i]++;
          if (m_run[i] == TO) begin
            m_sr[i]  = 1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [2:0] rd,
                      input logic [2:0] em);
    for (int k = 0; k < n; k++)
      apply(0, 0, 0, 2'b00, 0, rd, em, 3'b000);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("write_enb", int'(write_enb), int'(e.we));
      chk("fifo_full", int'(fifo_full), int'(e.ff));
      chk("valid_out", int'({valid_out_2, valid_out_1, valid_out_0}),
          int'(e.vo));
      chk("soft_rst", int'({soft_rst_2, soft_rst_1, soft_rst_0}),
          int'(e.sr));
      chk("addr_err", int'(addr_err), int'(e.ae));
`ifdef ROUTER_DROP_CNT_EN
      chk("drop_cnt", int'({drop_cnt_2, drop_cnt_1, drop_cnt_0}),
          int'(e.dc));
`endif
    end
  end

  initial begin
    int rdp, emp, seg;
    logic [2:0] em, rd;
    model_reset();
    reset = 1'b1; detect_add = 0; pkt_valid = 0; data_in = 0;
    write_enb_reg = 0;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0} = 3'b000;

    apply(1, 0, 0, 2'b00, 1, 3'b000, 3'b111, 3'b001);
    apply(1, 0, 0, 2'b00, 0, 3'b000, 3'b111, 3'b000);
    // Capture port 1, then write into a full FIFO 1.
    apply(0, 1, 1, 2'b01, 0, 3'b000, 3'b111, 3'b000);
    apply(0, 0, 0, 2'b00, 1, 3'b000, 3'b111, 3'b010);
    // Capture and write on the same edge use the old address.
    apply(0, 1, 1, 2'b11, 1, 3'b000, 3'b111, 3'b111);
    apply(0, 0, 0, 2'b00, 1, 3'b000, 3'b111, 3'b111);
    apply(0, 1, 1, 2'b10, 1, 3'b000, 3'b111, 3'b100);
    apply(0, 0, 0, 2'b00, 1, 3'b000, 3'b111, 3'b100);
    // Port 2 stall timeout, then the pulse falls.
    idle(31, 3'b000, 3'b011);
    idle(3, 3'b000, 3'b111);
    // Read on cycle 29 restarts the count.
    idle(28, 3'b000, 3'b011);
    idle(1, 3'b100, 3'b011);
    idle(31, 3'b000, 3'b011);
    idle(2, 3'b000, 3'b111);
    // Ports 0 and 1 together.
    idle(31, 3'b000, 3'b100);
    idle(2, 3'b000, 3'b111);
    // Reset at stall cycle 20 discards the timeout.
    idle(19, 3'b000, 3'b100);
    apply(1, 0, 0, 2'b00, 0, 3'b000, 3'b100, 3'b000);
    idle(12, 3'b000, 3'b100);
    idle(2, 3'b000, 3'b111);

    // Randomized segments with biased read/empty activity.
    for (int s = 0; s < 60; s++) begin
      int pick;
      pick = $urandom_range(0, 2);
      rdp = (pick == 0) ? 0 : (pick == 1) ? 3 : 40;
      emp = $urandom_range(0, 3);
      seg = $urandom_range(10, 80);
      em  = 3'($urandom_range(0, 7));
      for (int k = 0; k < seg; k++) begin
        if ($urandom_range(0, 99) < emp) em = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++)
          rd[i] = ($urandom_range(0, 99) < rdp);
        apply($urandom_range(0, 499) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              rd, em, 3'($urandom_range(0, 7)));
      end
    end

`ifdef ROUTER_DROP_CNT_EN
    apply(1, 0, 0, 2'b00, 0, 3'b000, 3'b111, 3'b000);
    idle(300 * TO + 3, 3'b000, 3'b110);
    idle(2, 3'b000, 3'b111);
`endif

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
